// File: rtl/serv_dbg_csr_access.sv
// Debug-side initiator that halts SERV and moves one 32-bit CSR value over the bit-serial CSR port.
// Latency: with the core already halted, o_rsp_valid rises 32 cycles after the accept edge; add halt-wait cycles otherwise.
// Backpressure: o_req_ready is high only in IDLE; the response is held stable until i_rsp_ready.
module serv_dbg_csr_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [11:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  input  logic        i_resume_req,
  output logic        o_dbg_halt,
  input  logic        i_halted,
  output logic [5:0]  o_csr_sel,
  output logic        o_csr_en,
  output logic        o_csr_we,
  output logic [4:0]  o_cnt,
  output logic        o_cnt_done,
  output logic        o_csr_wbit,
  input  logic        i_csr_rbit
);

  typedef enum logic [1:0] {IDLE, HALT, SHIFT, RESP} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  sel;
  logic        we_flag;
  logic [31:0] shreg;
  logic [4:0]  cnt;
  logic [15:0] tmo;
  logic        dbg_halt;
  logic [31:0] rdata;
  logic        err;

  logic [5:0]  dec_sel;
  logic [15:0] tmo_inc;
  logic [31:0] shreg_nxt;

  // One-hot select for the CSRs reachable over the serial port; zero means unsupported.
  function automatic logic [5:0] decode(input logic [11:0] addr);
    logic [5:0] s;
    s = 6'd0;
    case (addr)
      12'h300: s = 6'b000001;
      12'h301: s = 6'b000010;
      12'h304: s = 6'b000100;
      12'h342: s = 6'b001000;
      12'hF14: s = 6'b010000;
      12'h7B0: s = 6'b100000;
      default: s = 6'd0;
    endcase
    return s;
  endfunction

  assign dec_sel   = decode(i_req_addr);
  assign tmo_inc   = tmo + 16'd1;
  // Read bits enter at the top so bit 0 (captured first) ends up at shreg[0].
  assign shreg_nxt = {i_csr_rbit, shreg[31:1]};

  assign o_csr_sel   = sel;
  assign o_cnt       = cnt;
  assign o_csr_wbit  = shreg[0];
  assign o_dbg_halt  = dbg_halt;
  assign o_rsp_rdata = rdata;
  assign o_rsp_err   = err;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake/serial strobes.
  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_csr_en    = 1'b0;
    o_csr_we    = 1'b0;
    o_cnt_done  = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (dec_sel == 6'd0) state_nxt = RESP;
          else if (i_halted)   state_nxt = SHIFT;
          else                 state_nxt = HALT;
        end
      end
      HALT: begin
        // A halt ack arriving on the timeout cycle still wins.
        if (i_halted)                    state_nxt = SHIFT;
        else if (tmo_inc == TMO_LIMIT)   state_nxt = RESP;
      end
      SHIFT: begin
        o_csr_en   = 1'b1;
        o_csr_we   = we_flag;
        o_cnt_done = (cnt == 5'd31);
        if (!i_halted || cnt == 5'd31) state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, halt request, serial shifter, timeout counter and response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel      <= 6'd0;
      we_flag  <= 1'b0;
      shreg    <= 32'd0;
      cnt      <= 5'd0;
      tmo      <= 16'd0;
      dbg_halt <= 1'b0;
      rdata    <= 32'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            we_flag <= i_req_write;
            sel     <= dec_sel;
            shreg   <= i_req_wdata;
            cnt     <= 5'd0;
            tmo     <= 16'd0;
            if (dec_sel == 6'd0) begin
              rdata <= 32'd0;
              err   <= 1'b1;
            end else if (!i_halted) begin
              dbg_halt <= 1'b1;
            end
          end else if (i_resume_req) begin
            dbg_halt <= 1'b0;
          end
        end
        HALT: begin
          tmo <= tmo_inc;
          if (!i_halted && tmo_inc == TMO_LIMIT) begin
            rdata <= 32'd0;
            err   <= 1'b1;
          end
        end
        SHIFT: begin
          shreg <= shreg_nxt;
          if (!i_halted) begin
            // Core left halt mid-transfer: the partial value is meaningless.
            cnt   <= 5'd0;
            rdata <= 32'd0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              rdata <= shreg_nxt;
              err   <= 1'b0;
            end
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            err <= 1'b0;
            sel <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_dbg_csr_access.sv
// Scoreboard bench for serv_dbg_csr_access with a simple serial core model.
// A second instance with a short halt timeout covers the timeout path.
module tb_serv_dbg_csr_access;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_write, rsp_ready, resume_req, halted;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] core_val;
  logic        csr_rbit;
  logic        req_ready, rsp_valid, rsp_err, dbg_halt, csr_en, csr_we, cnt_done, csr_wbit;
  logic [31:0] rsp_rdata;
  logic [5:0]  csr_sel;
  logic [4:0]  cnt;

  logic        t4_req_valid, t4_rsp_ready, t4_resume, t4_halted;
  logic        t4_req_ready, t4_rsp_valid, t4_rsp_err, t4_dbg_halt, t4_csr_en, t4_csr_we;
  logic        t4_cnt_done, t4_csr_wbit;
  logic [31:0] t4_rsp_rdata;
  logic [5:0]  t4_csr_sel;
  logic [4:0]  t4_cnt;

  // Core model: presents the addressed bit of its CSR value in the same cycle as o_cnt.
  assign csr_rbit = core_val[cnt];

  serv_dbg_csr_access dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .i_resume_req(resume_req), .o_dbg_halt(dbg_halt), .i_halted(halted),
    .o_csr_sel(csr_sel), .o_csr_en(csr_en), .o_csr_we(csr_we), .o_cnt(cnt),
    .o_cnt_done(cnt_done), .o_csr_wbit(csr_wbit), .i_csr_rbit(csr_rbit)
  );

  serv_dbg_csr_access #(.TIMEOUT(4)) dut_t4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(t4_req_valid), .o_req_ready(t4_req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(t4_rsp_valid), .i_rsp_ready(t4_rsp_ready), .o_rsp_rdata(t4_rsp_rdata),
    .o_rsp_err(t4_rsp_err), .i_resume_req(t4_resume), .o_dbg_halt(t4_dbg_halt),
    .i_halted(t4_halted), .o_csr_sel(t4_csr_sel), .o_csr_en(t4_csr_en), .o_csr_we(t4_csr_we),
    .o_cnt(t4_cnt), .o_cnt_done(t4_cnt_done), .o_csr_wbit(t4_csr_wbit), .i_csr_rbit(1'b0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  // Scoreboard: compare each accepted response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      check_eq("sb_pending", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        check_eq("sb_rdata", rsp_rdata, e.rdata);
        check_eq("sb_err", rsp_err, e.err);
      end
    end
  end

  // Serial-port monitor: counter sequence, done strobe and captured write bits.
  int          en_run   = 0;
  int          en_total = 0;
  int          we_total = 0;
  int          cnt_bad  = 0;
  logic [31:0] wr_cap   = 32'd0;
  always @(negedge clk) begin
    if (rst_n && csr_en) begin
      if (cnt !== 5'(en_run)) cnt_bad++;
      if (cnt_done !== (cnt == 5'd31)) cnt_bad++;
      if (csr_we) begin
        wr_cap[cnt] = csr_wbit;
        we_total++;
      end
      en_run++;
      en_total++;
    end else begin
      en_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] wd);
    check_eq("req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Edges counted from the accept edge (which counts as 1) until o_rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int k;
    int e0;
    int w0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;
    rsp_ready = 1'b1; resume_req = 1'b0; halted = 1'b0; core_val = 32'h0;
    t4_req_valid = 1'b0; t4_rsp_ready = 1'b1; t4_resume = 1'b0; t4_halted = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_strobes", {rsp_valid, rsp_err, dbg_halt, csr_en, csr_we, cnt_done}, 6'b0);
    check_eq("rst_sel_cnt", {csr_sel, cnt}, 11'b0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Read dcsr with the core already halted.
    halted = 1'b1;
    core_val = 32'h4000_8043;
    exp_q.push_back('{rdata: 32'h4000_8043, err: 1'b0});
    e0 = en_total;
    send(1'b0, 12'h7B0, 32'h0);
    check_eq("rd_dcsr_sel", csr_sel, 6'b100000);
    check_eq("rd_dcsr_en", csr_en, 1'b1);
    wait_rsp(lat);
    check_eq("rd_dcsr_latency", lat, 33);
    check_eq("rd_dcsr_en_cycles", en_total - e0, 32);
    check_eq("cnt_sequence", cnt_bad, 0);
    tick();
    check_eq("rsp_drop", {rsp_valid, rsp_err, csr_sel}, 8'b0);

    // Write mie with the core running; halt ack five cycles after accept.
    halted = 1'b0;
    core_val = 32'h0000_0808;
    wr_cap = 32'h0;
    w0 = we_total;
    exp_q.push_back('{rdata: 32'h0000_0808, err: 1'b0});
    send(1'b1, 12'h304, 32'h0000_0080);
    check_eq("wr_halt_req", dbg_halt, 1'b1);
    check_eq("wr_no_en_before_ack", csr_en, 1'b0);
    repeat (4) tick();
    halted = 1'b1;
    wait_rsp(lat);
    check_eq("wr_rsp_seen", rsp_valid, 1'b1);
    check_eq("wr_we_cycles", we_total - w0, 32);
    check_eq("wr_serial_bits", wr_cap, 32'h0000_0080);
    check_eq("cnt_sequence_wr", cnt_bad, 0);
    tick();

    // Unsupported address: immediate error, no serial activity, halt untouched.
    halted = 1'b0;
    e0 = en_total;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    send(1'b0, 12'h305, 32'h0);
    wait_rsp(lat);
    check_eq("bad_addr_latency", lat, 1);
    check_eq("bad_addr_sel", csr_sel, 6'b0);
    tick();
    check_eq("bad_addr_no_en", en_total - e0, 0);
    check_eq("bad_addr_halt_kept", dbg_halt, 1'b1);

    // Request and resume together: request wins, halt stays set.
    halted = 1'b1;
    core_val = 32'h0000_1800;
    exp_q.push_back('{rdata: 32'h0000_1800, err: 1'b0});
    resume_req = 1'b1;
    send(1'b0, 12'h300, 32'h0);
    resume_req = 1'b0;
    check_eq("req_beats_resume", dbg_halt, 1'b1);
    wait_rsp(lat);
    check_eq("rd_mstatus_latency", lat, 33);
    tick();
    check_eq("halt_sticky", dbg_halt, 1'b1);
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    check_eq("resume_clears", dbg_halt, 1'b0);

    // Halt lost mid-shift, response held under backpressure.
    halted = 1'b1;
    core_val = 32'h4010_1105;
    rsp_ready = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    send(1'b0, 12'h301, 32'h0);
    k = 0;
    while (cnt != 5'd10 && k < 64) begin
      tick();
      k++;
    end
    check_eq("abort_reach_cnt10", cnt, 5'd10);
    halted = 1'b0;
    tick();
    check_eq("abort_en_low", {csr_en, csr_we}, 2'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_rdata_err", {rsp_rdata, rsp_err}, {32'h0, 1'b1});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("abort_rsp_done", rsp_valid, 1'b0);

    // Reset in the middle of a shift, then a clean read.
    halted = 1'b0;
    send(1'b0, 12'hF14, 32'h0);
    tick();
    halted = 1'b1;
    k = 0;
    while (cnt != 5'd20 && k < 64) begin
      tick();
      k++;
    end
    check_eq("pre_rst_cnt20", cnt, 5'd20);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", req_ready, 1'b1);
    check_eq("mid_rst_strobes", {rsp_valid, rsp_err, dbg_halt, csr_en, csr_we, cnt_done}, 6'b0);
    check_eq("mid_rst_sel_cnt", {csr_sel, cnt}, 11'b0);
    tick();
    rst_n = 1'b1;
    tick();
    core_val = 32'h8000_0001;
    exp_q.push_back('{rdata: 32'h8000_0001, err: 1'b0});
    send(1'b0, 12'hF14, 32'h0);
    wait_rsp(lat);
    check_eq("post_rst_latency", lat, 33);
    tick();

    // Halt timeout on the short-timeout instance.
    req_addr = 12'h300;
    req_write = 1'b0;
    check_eq("t4_ready", t4_req_ready, 1'b1);
    t4_req_valid = 1'b1;
    tick();
    t4_req_valid = 1'b0;
    check_eq("t4_halt_req", t4_dbg_halt, 1'b1);
    lat = 1;
    while (!t4_rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_eq("t4_timeout_latency", lat, 5);
    check_eq("t4_err", t4_rsp_err, 1'b1);
    check_eq("t4_rdata", t4_rsp_rdata, 32'h0);
    tick();
    check_eq("t4_rsp_done", t4_rsp_valid, 1'b0);
    check_eq("t4_halt_sticky", t4_dbg_halt, 1'b1);
    tick();
    check_eq("t4_halt_sticky2", t4_dbg_halt, 1'b1);
    t4_resume = 1'b1;
    tick();
    t4_resume = 1'b0;
    check_eq("t4_resume_clears", t4_dbg_halt, 1'b0);

    tick();
    check_eq("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
